// File: rtl/k2_pkg.sv
// rtl/k2_pkg.sv - shared state encoding and opcode constants for the K2 fetch sequencer
package k2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_RETIRE = 3'd4,
        ST_HALTED = 3'd5
    } fetch_state_t;

    // Opcode class lives in the top two instruction bits.
    localparam logic [1:0] OP_JMP = 2'b11;
    localparam logic [1:0] OP_JC  = 2'b10;

    localparam int N_INSTR_DEFAULT = 9;

endpackage

// File: rtl/step_edge_detect.sv
// rtl/step_edge_detect.sv - two-flop rising-edge detector for the single-step input
module step_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sig,
    output logic o_rise
);

    logic r_sig_d1;
    logic r_sig_d2;

    // Two-stage history of the input; a rise is "newest high, previous low".
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sig_d1 <= 1'b0;
            r_sig_d2 <= 1'b0;
        end else begin
            r_sig_d1 <= i_sig;
            r_sig_d2 <= r_sig_d1;
        end
    end

    assign o_rise = r_sig_d1 & ~r_sig_d2;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - K2 fetch/decode/execute sequencer; optional FETCH_SEQUENCER_SINGLE_STEP_EN
module fetch_sequencer
    import k2_pkg::*;
#(
    parameter int INSTR_W = 8,
    parameter int N_INSTR = N_INSTR_DEFAULT,
    parameter int PC_W    = $clog2(N_INSTR),
    parameter int LOOP_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               halt_req,
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
    input  logic               step,
`endif
    input  logic [PC_W-1:0]    pc_value,
    output logic               pc_inc,
    output logic               pc_load,
    output logic [2:0]         pc_load_val,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr_q,
    output logic               exec_valid,
    input  logic               exec_done,
    input  logic               carry_flag,
    output logic               busy,
    output logic               halted,
    output logic [LOOP_W-1:0]  loop_count
);

    localparam logic [PC_W-1:0] LP_LAST_PC = PC_W'(N_INSTR - 1);

    fetch_state_t        r_state;
    fetch_state_t        w_next_state;
    logic [INSTR_W-1:0]  r_instr_q;
    logic                r_is_jmp;
    logic                r_is_jc;
    logic [LOOP_W-1:0]   r_loop_count;

    logic                w_start_ok;
    logic                w_taken;
    logic                w_pc_inc;
    logic                w_pc_load;
    logic [2:0]          w_pc_load_val;
    logic                w_imem_req;
    logic [PC_W-1:0]     w_imem_addr;
    logic                w_exec_valid;

`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
    logic                w_step_rise;

    step_edge_detect u_step_edge (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_sig   (step),
        .o_rise  (w_step_rise)
    );

    assign w_start_ok = run & w_step_rise;
`else
    assign w_start_ok = run;
`endif

    // Carry is only looked at in RETIRE, so the decision is made late from the decoded class.
    assign w_taken = r_is_jmp | (r_is_jc & carry_flag);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-state handshake outputs.
    always_comb begin
        w_next_state  = r_state;
        w_pc_inc      = 1'b0;
        w_pc_load     = 1'b0;
        w_pc_load_val = 3'd0;
        w_imem_req    = 1'b0;
        w_imem_addr   = '0;
        w_exec_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_imem_req  = 1'b1;
                w_imem_addr = pc_value;
                if (imem_ack) begin
                    w_next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_next_state = ST_EXEC;
            end
            ST_EXEC: begin
                w_exec_valid = 1'b1;
                if (exec_done) begin
                    w_next_state = ST_RETIRE;
                end
            end
            ST_RETIRE: begin
                if (w_taken) begin
                    w_pc_load     = 1'b1;
                    w_pc_load_val = r_instr_q[2:0];
                end else begin
                    w_pc_inc      = 1'b1;
                end
                if (halt_req) begin
                    w_next_state = ST_HALTED;
                end else if (!run) begin
                    w_next_state = ST_IDLE;
                end else begin
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
                    w_next_state = ST_IDLE;
`else
                    w_next_state = ST_FETCH;
`endif
                end
            end
            ST_HALTED: begin
                w_next_state = ST_HALTED;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Instruction latch on the ack edge and opcode-class decode in DECODE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr_q <= '0;
            r_is_jmp  <= 1'b0;
            r_is_jc   <= 1'b0;
        end else begin
            if (r_state == ST_FETCH && imem_ack) begin
                r_instr_q <= imem_data;
            end
            if (r_state == ST_DECODE) begin
                r_is_jmp <= (r_instr_q[INSTR_W-1 -: 2] == OP_JMP);
                r_is_jc  <= (r_instr_q[INSTR_W-1 -: 2] == OP_JC);
            end
        end
    end

    // Program-wrap counter: sequential step off the last index, saturating.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_loop_count <= '0;
        end else if (w_pc_inc && pc_value == LP_LAST_PC && r_loop_count != '1) begin
            r_loop_count <= r_loop_count + LOOP_W'(1);
        end
    end

    assign pc_inc      = w_pc_inc;
    assign pc_load     = w_pc_load;
    assign pc_load_val = w_pc_load_val;
    assign imem_req    = w_imem_req;
    assign imem_addr   = w_imem_addr;
    assign exec_valid  = w_exec_valid;
    assign instr_q     = r_instr_q;
    assign loop_count  = r_loop_count;
    assign busy        = (r_state != ST_IDLE) && (r_state != ST_HALTED);
    assign halted      = (r_state == ST_HALTED);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    localparam int PC_W = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic       halt_req = 1'b0;
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
    logic       step = 1'b0;
`endif
    logic [3:0] pc = 4'd0;
    logic       pc_inc, pc_load;
    logic [2:0] pc_load_val;
    logic       imem_req;
    logic [3:0] imem_addr;
    logic       imem_ack = 1'b0;
    logic [7:0] imem_data = 8'd0;
    logic [7:0] instr_q;
    logic       exec_valid;
    logic       exec_done = 1'b0;
    logic       carry_flag = 1'b0;
    logic       busy, halted;
    logic [7:0] loop_count;

    logic [7:0] mem [0:8];
    int         done_delay = 0;
    int         exec_cnt = 0;
    logic       ack_hold = 1'b0;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;

    fetch_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .halt_req    (halt_req),
`ifdef FETCH_SEQUENCER_SINGLE_STEP_EN
        .step        (step),
`endif
        .pc_value    (pc),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .instr_q     (instr_q),
        .exec_valid  (exec_valid),
        .exec_done   (exec_done),
        .carry_flag  (carry_flag),
        .busy        (busy),
        .halted      (halted),
        .loop_count  (loop_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External instruction counter driven by the sequencer's pulses.
    always @(posedge clk or negedge reset) begin
        if (!reset)        pc <= 4'd0;
        else if (pc_load)  pc <= {1'b0, pc_load_val};
        else if (pc_inc)   pc <= (pc == 4'd8) ? 4'd0 : pc + 4'd1;
    end

    // Memory and datapath responders, updated away from the active edge.
    always @(negedge clk) begin
        if (imem_req && !ack_hold) begin
            imem_ack  = 1'b1;
            imem_data = mem[imem_addr];
        end else begin
            imem_ack  = 1'b0;
        end
        exec_done = exec_valid && (exec_cnt >= done_delay);
        exec_cnt  = exec_valid ? exec_cnt + 1 : 0;
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        run = 1'b0;
        halt_req = 1'b0;
        carry_flag = 1'b0;
        ack_hold = 1'b0;
        done_delay = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic fill_alu(input logic [7:0] base);
        for (int i = 0; i < 9; i++) mem[i] = base + 8'(i);
    endtask

    task automatic wait_retire(output logic inc, output logic ld, output logic [2:0] val, output int at);
        logic found;
        found = 1'b0;
        inc = 1'b0; ld = 1'b0; val = 3'd0; at = 0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (pc_inc || pc_load) begin
                found = 1'b1;
                inc = pc_inc; ld = pc_load; val = pc_load_val; at = cyc;
            end
        end
        if (!found) check_vec("retire_timeout", 32'(found), 1);
    endtask

    logic       r_inc, r_ld;
    logic [2:0] r_val;
    int         t_at, t_prev, t0, n_ret;
    logic       seen;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        fill_alu(8'h10);
        do_reset();
        @(negedge clk);
        check_vec("rst_busy", busy, 0);
        check_vec("rst_halted", halted, 0);
        check_vec("rst_imem_req", imem_req, 0);
        check_vec("rst_exec_valid", exec_valid, 0);
        check_vec("rst_pc_inc", pc_inc, 0);
        check_vec("rst_pc_load", pc_load, 0);
        check_vec("rst_pc_load_val", pc_load_val, 0);
        check_vec("rst_instr_q", instr_q, 0);
        check_vec("rst_loop_count", loop_count, 0);

`ifndef FETCH_SEQUENCER_SINGLE_STEP_EN
        // Sequential program: one retire every 4 cycles, wrap counted once.
        run = 1'b1;
        t0 = cyc;
        t_prev = t0;
        for (int i = 0; i < 9; i++) begin
            wait_retire(r_inc, r_ld, r_val, t_at);
            check_vec($sformatf("seq_inc_%0d", i), r_inc, 1);
            check_vec($sformatf("seq_period_%0d", i), t_at - t_prev, 4);
            t_prev = t_at;
        end
        @(negedge clk);
        check_vec("seq_loop_count", loop_count, 1);
        check_vec("seq_pc_wrapped", pc, 0);
        check_vec("seq_fetch_addr", imem_addr, 0);

        // Drive the wrap counter to saturation and beyond.
        for (int i = 0; i < 9 * 254; i++) wait_retire(r_inc, r_ld, r_val, t_at);
        @(negedge clk);
        check_vec("sat_loop_255", loop_count, 255);
        for (int i = 0; i < 9; i++) wait_retire(r_inc, r_ld, r_val, t_at);
        @(negedge clk);
        check_vec("sat_loop_hold", loop_count, 255);

        // Unconditional jump at index 2.
        do_reset();
        fill_alu(8'h20);
        mem[2] = 8'hC5;
        run = 1'b1;
        wait_retire(r_inc, r_ld, r_val, t_at);
        wait_retire(r_inc, r_ld, r_val, t_at);
        wait_retire(r_inc, r_ld, r_val, t_at);
        check_vec("jmp_load", r_ld, 1);
        check_vec("jmp_inc", r_inc, 0);
        check_vec("jmp_target", r_val, 5);
        @(negedge clk);
        check_vec("jmp_pc", pc, 5);
        check_vec("jmp_loop_count", loop_count, 0);
        wait_retire(r_inc, r_ld, r_val, t_at);
        check_vec("jmp_next_inc", r_inc, 1);

        // Conditional jump: not taken, then taken.
        do_reset();
        fill_alu(8'h30);
        mem[0] = 8'h83;
        mem[1] = 8'h83;
        run = 1'b1;
        wait_retire(r_inc, r_ld, r_val, t_at);
        check_vec("jc_nt_inc", r_inc, 1);
        check_vec("jc_nt_load", r_ld, 0);
        @(posedge clk);
        #1 carry_flag = 1'b1;
        wait_retire(r_inc, r_ld, r_val, t_at);
        check_vec("jc_t_load", r_ld, 1);
        check_vec("jc_t_inc", r_inc, 0);
        check_vec("jc_t_target", r_val, 3);
        @(negedge clk);
        check_vec("jc_t_pc", pc, 3);

        // Halt requested mid-EXEC with a slow datapath.
        do_reset();
        fill_alu(8'h40);
        done_delay = 3;
        run = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = exec_valid;
        end
        check_vec("halt_exec_seen", seen, 1);
        halt_req = 1'b1;
        wait_retire(r_inc, r_ld, r_val, t_at);
        check_vec("halt_retire_inc", r_inc, 1);
        @(negedge clk);
        check_vec("halt_halted", halted, 1);
        check_vec("halt_busy", busy, 0);
        check_vec("halt_pc", pc, 1);
        run = 1'b0;
        repeat (2) @(negedge clk);
        run = 1'b1;
        repeat (3) @(negedge clk);
        check_vec("halt_sticky", halted, 1);
        check_vec("halt_no_fetch", imem_req, 0);
        check_vec("halt_busy_after", busy, 0);

        // Asynchronous reset while a fetch is stalled.
        do_reset();
        fill_alu(8'h21);
        run = 1'b1;
        for (int i = 0; i < 10; i++) wait_retire(r_inc, r_ld, r_val, t_at);
        ack_hold = 1'b1;
        @(negedge clk);
        check_vec("arst_pre_req", imem_req, 1);
        check_vec("arst_pre_loop", loop_count, 1);
        check_vec("arst_pre_instr", instr_q, 8'h21);
        #2 reset = 1'b0;
        #1;
        check_vec("arst_req", imem_req, 0);
        check_vec("arst_busy", busy, 0);
        check_vec("arst_instr", instr_q, 0);
        check_vec("arst_loop", loop_count, 0);
        ack_hold = 1'b0;
        @(negedge clk);
        reset = 1'b1;
`else
        // Single step: nothing runs until a step edge, one retire per edge.
        run = 1'b1;
        repeat (6) @(negedge clk);
        check_vec("ss_idle_busy", busy, 0);
        check_vec("ss_idle_req", imem_req, 0);
        n_ret = 0;
        for (int p = 0; p < 2; p++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            for (int n = 0; n < 12; n++) begin
                @(negedge clk);
                if (pc_inc || pc_load) n_ret++;
            end
            check_vec($sformatf("ss_retires_%0d", p), n_ret, p + 1);
            check_vec($sformatf("ss_busy_%0d", p), busy, 0);
        end
        check_vec("ss_pc", pc, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
